// File: rtl/lut_dac_spi_serializer.sv
// Double-buffered DAC frame serializer: one holding register feeds a shift register that
// drives a mode-0 SPI link (CPOL=0, MSB first) with a guaranteed CSN-high gap between frames.
module lut_dac_spi_serializer #(
    parameter int unsigned BIT_WIDTH = 12,
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned FRAME_GAP = 2,
    parameter int unsigned SIGNED_IN = 1
) (
    input  logic                 CLK_SYS,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [BIT_WIDTH-1:0] DATA_IN,
    input  logic                 DATA_VALID,
    output logic                 DATA_READY,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic                 LAST_IN,
    output logic                 SPI_SCLK,
    output logic                 SPI_MOSI,
    output logic                 SPI_CSN,
    output logic                 BUSY,
    output logic                 FRAME_DONE,
    output logic                 LAST_OUT
);

    localparam int unsigned FRAME_LEN = CMD_WIDTH + BIT_WIDTH;
    localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned GAP_W     = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_t;

    state_t               state;
    logic                 hold_full;
    logic                 hold_last;
    logic [FRAME_LEN-1:0] hold_word;
    logic [FRAME_LEN-1:0] shift_reg;
    logic                 shift_last;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 sclk_q;
    logic                 mosi_q;
    logic                 csn_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 last_q;

    logic [BIT_WIDTH-1:0] fmt_data;
    logic                 accept;
    logic                 gap_end;
    logic                 load;

    assign DATA_READY = EN & ~hold_full & ~RST;
    assign accept     = DATA_VALID & DATA_READY;
    assign gap_end    = (state == StGap) && (gap_cnt == GAP_LAST);
    // Hold-to-shift hand-off only when the link is free; EN low suppresses it so a dropped
    // sample can never start a frame.
    assign load       = hold_full & EN & ((state == StIdle) | gap_end);

    assign SPI_SCLK   = sclk_q;
    assign SPI_MOSI   = mosi_q;
    assign SPI_CSN    = csn_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign LAST_OUT   = last_q;

    // Two's complement to offset binary: flip the sign bit
    always_comb begin
        fmt_data = DATA_IN;
        if (SIGNED_IN != 0) begin
            fmt_data[BIT_WIDTH-1] = ~DATA_IN[BIT_WIDTH-1];
        end
    end

    // Holding register: capture on handshake, release on hand-off, discard when disabled
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            hold_full <= 1'b0;
            hold_last <= 1'b0;
            hold_word <= '0;
        end else if (!EN) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_word <= {CMD, fmt_data};
            hold_last <= LAST_IN;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Frame FSM with registered SPI pins and status pulses
    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            state      <= StIdle;
            shift_reg  <= '0;
            shift_last <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            csn_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            last_q <= 1'b0;
            if (load) begin
                state      <= StShift;
                shift_reg  <= hold_word;
                shift_last <= hold_last;
                mosi_q     <= hold_word[FRAME_LEN-1];
                csn_q      <= 1'b0;
                sclk_q     <= 1'b0;
                busy_q     <= 1'b1;
                div_cnt    <= '0;
                bit_cnt    <= '0;
            end else begin
                case (state)
                    StIdle: begin
                        busy_q <= 1'b0;
                    end
                    StShift: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            if (!sclk_q) begin
                                sclk_q <= 1'b1;
                            end else begin
                                sclk_q <= 1'b0;
                                if (bit_cnt == BIT_LAST) begin
                                    // Last falling edge closes the frame
                                    csn_q   <= 1'b1;
                                    mosi_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    last_q  <= shift_last;
                                    bit_cnt <= '0;
                                    gap_cnt <= '0;
                                    state   <= StGap;
                                end else begin
                                    shift_reg <= shift_reg << 1;
                                    mosi_q    <= shift_reg[FRAME_LEN-2];
                                    bit_cnt   <= bit_cnt + BIT_W'(1);
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    StGap: begin
                        if (gap_end) begin
                            state  <= StIdle;
                            busy_q <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
